riscv_data_mem_responder: RTL and testbench
===========================================

// Module: riscv_data_mem_responder
// PURPOSE
// - Data-memory responder for the RISC-V core's load/store unit. It is the target end of the core's memory access path.
// - Accepts one request at a time over a valid/ready channel. Byte/half/word granularity, RV32I funct3 size encoding.
// - Performs read-modify-write for sub-word stores and sign/zero extension for loads.
// - Flags misaligned, out-of-range and illegal-size accesses, and returns an error response instead of touching memory.
// PARAMETERS
// - DEPTH   1024  number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1
// - IO_WORD 512   word index of the output-port register (used only with MEM_IO_PORT_EN)
// PORTS
// - clk        in   1   clock, all state updates on posedge
// - rst        in   1   reset: asynchronous, active-low
// - req_valid  in   1   request present
// - req_ready  out  1   responder can accept a request
// - req_write  in   1   1 = store, 0 = load
// - req_addr   in   32  byte address
// - req_funct3 in   3   0 = b, 1 = h, 2 = w, 4 = bu, 5 = hu (loads); 0/1/2 (stores)
// - req_wdata  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - rsp_valid  out  1   response present
// - rsp_ready  in   1   consumer accepts response
// - rsp_rdata  out  32  load result, extended; 0 for stores and errors
// - rsp_error  out  1   access faulted, no side effect
// - io_out8    out  8   output-port register
// BEHAVIOUR
// - Reset: state = IDLE; req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, io_out8 = 0. Memory contents are not reset.
// - FSM states: IDLE, ACCESS, RESP.
//   - IDLE: req_ready = 1. A request is taken on req_valid & req_ready and all request fields are latched.
//     - Faulting request: go to RESP with rsp_error = 1.
//     - Otherwise: issue a synchronous read of word addr[31:2] and go to ACCESS.
//   - ACCESS: read word available (one-cycle latency).
//     - Load: select lane by addr[1:0], extend, register into rsp_rdata.
//     - Store: merge req_wdata into the selected lanes and write the word back on the edge leaving ACCESS.
//     - Then go to RESP.
//   - RESP: rsp_valid = 1. rsp_rdata and rsp_error are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
//     rsp_ready held high back-to-back gives one request per 3 cycles.
// - req_ready = 0 in ACCESS and RESP. There is no request buffering.
// - Latency: accept edge T0 -> rsp_valid from T0+2 (good access) or T0+1 (fault).
// - Fault rules, checked at accept:
//   - half with addr[0] = 1
//   - word with addr[1:0] != 0
//   - funct3 in {3, 6, 7}, or funct3 in {4, 5} with req_write = 1
//   - addr[31:2] >= DEPTH
//   - A faulting store never writes memory or io_out8.
// - Load extension: b/h sign-extend from bit 7/15; bu/hu zero-extend; w unchanged.
//   Half lanes: addr[1] = 0 selects [15:0], addr[1] = 1 selects [31:16].
// - Store merge: only the addressed byte/half lane changes; other lanes keep the value read in ACCESS.
// - Reset asserted mid-operation: the FSM returns to IDLE immediately.
//   - A store not yet past the ACCESS->RESP edge is dropped.
//   - A pending response is discarded.
// - Back-to-back accesses to the same word observe the prior write, because requests are strictly serialized.
// CONFIGURATION
// - MEM_IO_PORT_EN defined:
//   - A store whose word index == IO_WORD also loads io_out8 with the new value of byte 0 of that word, in the same cycle as the memory write.
//   - Loads from IO_WORD return memory contents normally.
// - MEM_IO_PORT_EN undefined: io_out8 is tied to 0, IO_WORD is ordinary memory, and no extra logic is present.
// TESTING
// - sw 0x8000F0A5 @0x10, then lw @0x10 -> rsp_rdata = 0x8000F0A5, rsp_error = 0, rsp_valid 2 cycles after accept.
// - Word 0x11223344 @0x20:
//   - sb 0xAB @0x21 -> word = 0x1122AB44
//   - lb @0x21 -> 0xFFFFFFAB
//   - lbu @0x21 -> 0x000000AB
//   - lh @0x22 -> 0x00001122
// - lh @0x23; sw @0x02; lw @0x1000 (DEPTH = 1024); funct3 = 3 -> rsp_error = 1 one cycle after accept, rsp_rdata = 0, memory unchanged.
// - Hold rsp_ready = 0 for 5 cycles during RESP -> rsp_valid/rsp_rdata stable, req_ready = 0. Release -> req_ready = 1 next cycle.
// - sh 0xBEEF @0x30 then drop rst in ACCESS -> word @0x30 unchanged, all outputs at reset values, req_ready = 1.
// - MEM_IO_PORT_EN: sw 0x0000005A @0x800 -> io_out8 = 0x5A. Without the macro -> io_out8 stays 0 and lw @0x800 = 0x5A.

Source files
------------

// File: rtl/riscv_data_mem_responder_if.sv
// Load/store request and response channel between the core LSU (master) and the data memory (slave).
interface riscv_data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/riscv_data_mem_responder.sv
// Single-outstanding RV32I data-memory responder with sub-word RMW stores, load extension and fault reporting.
// Optional MEM_IO_PORT_EN: stores to word IO_WORD also update the io_out8 output-port register.
module riscv_data_mem_responder #(
  parameter int unsigned DEPTH = 1024
`ifdef MEM_IO_PORT_EN
  , parameter int unsigned IO_WORD = 512
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  riscv_data_mem_responder_if.slave    bus,
  output logic [7:0]                   io_out8
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               write_q, write_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_word_q;
  logic               mem_rd_en;
  logic               mem_we;
  logic               fault;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_val;
  logic [31:0]        wr_word;

  // Fault classification of the request currently offered on the bus
  always_comb begin
    fault = 1'b0;
    case (bus.req_funct3)
      3'd0:    fault = 1'b0;
      3'd1:    fault = bus.req_addr[0];
      3'd2:    fault = |bus.req_addr[1:0];
      3'd4:    fault = bus.req_write;
      3'd5:    fault = bus.req_write | bus.req_addr[0];
      default: fault = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH) fault = 1'b1;
  end

  // Lane extraction for loads and lane merge for stores from the word read in ACCESS
  always_comb begin
    lane_b = rd_word_q[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (funct3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_val = {24'h000000, lane_b};
      3'd5:    load_val = {16'h0000, lane_h};
      default: load_val = rd_word_q;
    endcase
    wr_word = rd_word_q;
    case (funct3_q)
      3'd0: wr_word[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      3'd1: begin
        if (off_q[1]) wr_word[31:16] = wdata_q[15:0];
        else          wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mem_rd_en   = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d     = bus.req_write;
          funct3_d    = bus.req_funct3;
          off_d       = bus.req_addr[1:0];
          idx_d       = bus.req_addr[IDX_W+1:2];
          wdata_d     = bus.req_wdata;
          rsp_rdata_d = 32'h0000_0000;
          rsp_error_d = fault;
          mem_rd_en   = ~fault;
          state_d     = fault ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_we      = write_q;
        rsp_rdata_d = write_q ? 32'h0000_0000 : load_val;
        rsp_error_d = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_error_q <= 1'b0;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      idx_q       <= '0;
      wdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
    end
  end

  // Storage array is deliberately not reset; writes only happen on the edge leaving ACCESS
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wr_word;
    if (mem_rd_en) rd_word_q <= mem[bus.req_addr[IDX_W+1:2]];
  end

`ifdef MEM_IO_PORT_EN
  logic [7:0] io_out8_q, io_out8_d;

  always_comb begin
    io_out8_d = io_out8_q;
    if (mem_we && (idx_q == IDX_W'(IO_WORD))) io_out8_d = wr_word[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) io_out8_q <= 8'h00;
    else      io_out8_q <= io_out8_d;
  end

  assign io_out8 = io_out8_q;
`else
  assign io_out8 = 8'h00;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Randomized self-checking bench for riscv_data_mem_responder against a byte-addressed reference memory.
module tb_riscv_data_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned IO_WORD = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] io_out8;

  riscv_data_mem_responder_if bus();

  riscv_data_mem_responder dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .io_out8 (io_out8)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mb [4*DEPTH];
  logic [7:0] io_exp = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: applies the access to a flat byte memory, returns expected error and load data
  function automatic void ref_access(input bit w, input logic [31:0] a, input logic [2:0] f3,
                                     input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int          size;
    logic [31:0] v;
    err = 1'b0;
    rd  = 32'h0;
    v   = 32'h0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin size = 1; err = 1'b1; end
    endcase
    if (w && f3 > 3'd2) err = 1'b1;
    if ((a % 32'(size)) != 0) err = 1'b1;
    if (a >= 32'(4*DEPTH)) err = 1'b1;
    if (err) return;
    if (w) begin
      for (int i = 0; i < size; i++) mb[a+32'(i)] = wd[8*i +: 8];
`ifdef MEM_IO_PORT_EN
      if ((a / 4) == 32'(IO_WORD)) io_exp = mb[4*IO_WORD];
`endif
    end else begin
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a+32'(i)];
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      rd = v;
    end
  endfunction

  task automatic xact(input bit w, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input int hold);
    bit          e_err;
    logic [31:0] e_rd;
    int          lat;
    ref_access(w, a, f3, wd, e_err, e_rd);
    @(negedge clk);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("rsp_latency", 32'(lat), e_err ? 32'd1 : 32'd2);
    check_eq("rsp_error", 32'(bus.rsp_error), 32'(e_err));
    check_eq("rsp_rdata", bus.rsp_rdata, e_rd);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rsp_rdata", bus.rsp_rdata, e_rd);
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check_eq("req_ready_back", 32'(bus.req_ready), 32'd1);
    check_eq("io_out8", 32'(io_out8), 32'(io_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check_eq({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
    check_eq({tag, "_io_out8"}, 32'(io_out8), 32'd0);
  endtask

  // Half store to 0x30 aborted by reset while the read word is in flight
  task automatic reset_in_access();
    @(negedge clk);
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h30;
    bus.req_funct3 = 3'd1;
    bus.req_wdata  = 32'h0000_BEEF;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    io_exp = 8'h00;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int          pool [18];
    logic [31:0] a;
    logic [2:0]  f3;
    bit          w;
    int          k;

    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'd0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) pool[i] = i;
    pool[16] = IO_WORD;
    pool[17] = DEPTH - 1;
    for (int i = 0; i < 18; i++) xact(1'b1, 32'(pool[i] * 4), 3'd2, $urandom, 0);

    xact(1'b1, 32'h10, 3'd2, 32'h8000_F0A5, 0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, 0);
    xact(1'b1, 32'h20, 3'd2, 32'h1122_3344, 0);
    xact(1'b1, 32'h21, 3'd0, 32'h0000_00AB, 0);
    xact(1'b0, 32'h20, 3'd2, 32'h0, 0);
    xact(1'b0, 32'h21, 3'd0, 32'h0, 0);
    xact(1'b0, 32'h21, 3'd4, 32'h0, 0);
    xact(1'b0, 32'h22, 3'd1, 32'h0, 0);
    xact(1'b0, 32'h23, 3'd1, 32'h0, 0);
    xact(1'b1, 32'h02, 3'd2, 32'hDEAD_BEEF, 0);
    xact(1'b0, 32'h1000, 3'd2, 32'h0, 0);
    xact(1'b0, 32'h20, 3'd3, 32'h0, 0);
    xact(1'b1, 32'h20, 3'd4, 32'hFFFF_FFFF, 0);
    xact(1'b0, 32'h00, 3'd2, 32'h0, 0);
    xact(1'b0, 32'h20, 3'd2, 32'h0, 0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, 5);
    xact(1'b1, 32'h800, 3'd2, 32'h0000_005A, 0);
    xact(1'b0, 32'h800, 3'd2, 32'h0, 0);

    reset_in_access();
    xact(1'b0, 32'h30, 3'd2, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 17));
      a = 32'(pool[k] * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0001_0000;
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      xact(w, a, f3, $urandom, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
